// File: rtl/sp_memory_rr_arbiter.sv
// Round-robin arbiter sharing one sp_memory native port among NUM_REQ requesters.
// Grants are combinational; read data returns through a tag pipe that matches the memory read latency.
module sp_memory_rr_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 1024,
  parameter  int READ_LAT = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int SW       = WIDTH / 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   sleep,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [NUM_REQ*AW-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*SW-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [WIDTH-1:0]       rdata,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  output logic [SW-1:0]          mem_wstrb,
  input  logic [WIDTH-1:0]       mem_rdata
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0] r_prio_ptr;
  logic           r_lock_vld;
  logic [IDW-1:0] r_lock_owner;
  logic           r_tag_vld [READ_LAT];
  logic [IDW-1:0] r_tag_id  [READ_LAT];

  logic           w_win_vld;
  logic [IDW-1:0] w_win_id;
  logic           w_rd_acc;
  logic [IDW-1:0] w_next_ptr;

  // Handshake: an access transfers in the cycle where req[i] and gnt[i] are both high;
  // the requester keeps req and its payload stable until then, and may withdraw req before it.
  always_comb begin
    int idx;
    w_win_vld = 1'b0;
    w_win_id  = '0;
    idx       = 0;
    if (aresetn && !sleep) begin
      if (r_lock_vld) begin
        w_win_vld = req[r_lock_owner];
        w_win_id  = r_lock_owner;
      end else begin
        // Scan from the far end so the last hit written is the first in round-robin order.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          idx = int'(r_prio_ptr) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (req[idx]) begin
            w_win_vld = 1'b1;
            w_win_id  = IDW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_win_vld) gnt[w_win_id] = 1'b1;
  end

  assign w_rd_acc   = w_win_vld && !req_we[w_win_id];
  assign w_next_ptr = (w_win_id == IDW'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;

  assign mem_cs    = w_win_vld;
  assign mem_we    = w_win_vld && req_we[w_win_id];
  assign mem_addr  = w_win_vld ? req_addr[w_win_id*AW +: AW] : '0;
  assign mem_wdata = w_win_vld ? req_wdata[w_win_id*WIDTH +: WIDTH] : '0;
  assign mem_wstrb = w_win_vld ? req_wstrb[w_win_id*SW +: SW] : '0;
  assign rdata     = mem_rdata;

  always_comb begin
    rvalid = '0;
    if (r_tag_vld[READ_LAT-1]) rvalid[r_tag_id[READ_LAT-1]] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prio_ptr   <= '0;
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_id[s]  <= '0;
      end
    end else begin
      // The tag pipe keeps advancing during sleep so reads already issued still return.
      r_tag_vld[0] <= w_rd_acc;
      r_tag_id[0]  <= w_win_id;
      for (int s = 1; s < READ_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      if (w_win_vld) begin
        r_prio_ptr   <= w_next_ptr;
        r_lock_vld   <= req_lock[w_win_id];
        r_lock_owner <= w_win_id;
      end else if (r_lock_vld && !sleep && !req[r_lock_owner]) begin
        r_lock_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sp_memory_rr_arbiter.sv
// Bench for sp_memory_rr_arbiter: grant table, hand sequences, random traffic vs a reference model.
module tb_sp_memory_rr_arbiter;

  localparam int N = 4, W = 32, DEPTH = 1024, RL = 2, AW = 10, SW = 4;

  logic aclk = 1'b0, aresetn = 1'b0, sleep = 1'b0;
  logic [N-1:0]    req = '0, req_we = '0, req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0]  req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [W-1:0]    rdata, mem_wdata, mem_rdata;
  logic            mem_cs, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [SW-1:0]   mem_wstrb;

  sp_memory_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .READ_LAT(RL)) dut (
    .aclk(aclk), .aresetn(aresetn), .sleep(sleep), .req(req), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- memory behind the arbiter (RL-cycle read) ----------------
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_p1, rd_p2;
  function automatic logic [W-1:0] init_word(int i);
    return 32'h5A5A_0000 ^ (i * 32'h9E37_79B1);
  endfunction
  initial for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
  always @(posedge aclk) begin
    if (mem_cs && mem_we)
      for (int b = 0; b < SW; b++) if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
    rd_p1 <= mem[mem_addr];
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  // ---------------- reference model and scoreboard ----------------
  int           checks = 0, failures = 0, cyc = 0;
  int           m_prio, m_lock;
  logic [W-1:0] shadow [DEPTH];
  int           exp_rv_at [int];
  logic [W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_lock = -1;
    exp_rv_at.delete();
    exp_q.delete();
  endtask

  function automatic int model_winner();
    if (sleep) return -1;
    if (m_lock >= 0) return req[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) if (req[(m_prio + k) % N]) return (m_prio + k) % N;
    return -1;
  endfunction

  // One clock cycle: inputs already applied; compare at negedge, advance model, return at posedge+1.
  task automatic cycle(output logic [N-1:0] g, output logic [N-1:0] rv, output logic [W-1:0] rd);
    int w;
    logic [N-1:0]  eg, erv;
    logic [47:0]   ebus;
    logic [AW-1:0] a;
    @(negedge aclk);
    g = gnt; rv = rvalid; rd = rdata;
    w = model_winner();
    eg = '0; ebus = '0; erv = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      a = req_addr[w*AW +: AW];
      ebus = {1'b1, req_we[w], a, req_wdata[w*W +: W], req_wstrb[w*SW +: SW]};
    end
    chk("gnt", gnt, eg);
    chk("mem_bus", {mem_cs, mem_we, mem_addr, mem_wdata, mem_wstrb}, ebus);
    if (exp_rv_at.exists(cyc)) begin
      erv[exp_rv_at[cyc]] = 1'b1;
      exp_rv_at.delete(cyc);
    end
    chk("rvalid", rvalid, erv);
    if (erv != '0 && exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
    if (w >= 0) begin
      m_prio = (w + 1) % N;
      m_lock = req_lock[w] ? w : -1;
      if (req_we[w]) begin
        for (int b = 0; b < SW; b++)
          if (req_wstrb[w*SW + b]) shadow[a][b*8 +: 8] = req_wdata[w*W + b*8 +: 8];
      end else begin
        exp_rv_at[cyc + RL] = w;
        exp_q.push_back(shadow[a]);
      end
    end else if (!sleep && m_lock >= 0 && !req[m_lock]) begin
      m_lock = -1;
    end
    cyc++;
    @(posedge aclk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_slot(int i, logic we, logic [AW-1:0] a, logic [W-1:0] d, logic [SW-1:0] s);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic         slp;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t         tbl [18];
  logic [N-1:0] g, rv;
  logic [W-1:0] rd;
  int           n, grants, rvs;
  bit           found;

  initial begin
    tbl = '{
      '{4'b1111, 4'b0000, 1'b0, 4'b0001}, '{4'b1111, 4'b0000, 1'b0, 4'b0010},
      '{4'b1111, 4'b0000, 1'b0, 4'b0100}, '{4'b1111, 4'b0000, 1'b0, 4'b1000},
      '{4'b1111, 4'b0000, 1'b0, 4'b0001},
      '{4'b0101, 4'b0000, 1'b1, 4'b0000}, '{4'b0101, 4'b0000, 1'b1, 4'b0000},
      '{4'b0101, 4'b0000, 1'b0, 4'b0100}, '{4'b0101, 4'b0000, 1'b0, 4'b0001},
      '{4'b0000, 4'b0000, 1'b0, 4'b0000},
      '{4'b0101, 4'b0100, 1'b0, 4'b0100}, '{4'b0101, 4'b0100, 1'b0, 4'b0100},
      '{4'b0101, 4'b0100, 1'b0, 4'b0100}, '{4'b0101, 4'b0000, 1'b0, 4'b0100},
      '{4'b0101, 4'b0000, 1'b0, 4'b0001},
      '{4'b0100, 4'b0100, 1'b0, 4'b0100}, '{4'b0001, 4'b0000, 1'b0, 4'b0000},
      '{4'b0001, 4'b0000, 1'b0, 4'b0001}
    };
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    model_reset();

    // Reset state with every requester asking.
    req = 4'b1111;
    @(negedge aclk);
    chk("reset_gnt", gnt, '0);
    chk("reset_cs", mem_cs, 1'b0);
    chk("reset_rvalid", rvalid, '0);
    @(posedge aclk);
    #1;
    req = '0;
    aresetn = 1'b1;

    // Grant table: rotation, sleep, lock hold/release.
    for (int i = 0; i < N; i++) set_slot(i, 1'b0, AW'(32 + i), $urandom, 4'hF);
    for (int v = 0; v < 18; v++) begin
      req = tbl[v].req; req_lock = tbl[v].lock; sleep = tbl[v].slp;
      cycle(g, rv, rd);
      chk($sformatf("tbl%0d", v), g, tbl[v].exp_gnt);
    end
    req = '0; req_lock = '0; sleep = 1'b0;
    repeat (RL + 1) cycle(g, rv, rd);

    // Write from requester 1, read back through requester 3.
    set_slot(1, 1'b1, 10'h10, 32'hA5A5_A5A5, 4'hF);
    req = 4'b0010;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin cycle(g, rv, rd); found = g[1]; end
    chk("wr_granted", found, 1'b1);
    set_slot(3, 1'b0, 10'h10, '0, 4'h0);
    req = 4'b1000;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin cycle(g, rv, rd); found = g[3]; end
    chk("rd_granted", found, 1'b1);
    req = '0;
    found = 0;
    n = 0;
    for (int k = 0; k < RL + 3 && !found; k++) begin
      cycle(g, rv, rd);
      n++;
      found = rv[3];
      if (found) chk("wr_rd_data", rd, 32'hA5A5_A5A5);
    end
    chk("wr_rd_rvalid_seen", found, 1'b1);
    chk("wr_rd_latency", n, RL);

    // Alternating back-to-back reads from requesters 0 and 3.
    grants = 0;
    rvs = 0;
    for (int k = 0; k < 12; k++) begin
      set_slot(0, 1'b0, AW'($urandom_range(0, 31)), '0, 4'h0);
      set_slot(3, 1'b0, AW'($urandom_range(0, 31)), '0, 4'h0);
      req = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      cycle(g, rv, rd);
      if (g != '0) grants++;
      if (rv != '0) rvs++;
    end
    req = '0;
    for (int k = 0; k < RL + 1; k++) begin cycle(g, rv, rd); if (rv != '0) rvs++; end
    chk("alt_grants", grants, 12);
    chk("alt_rvalids", rvs, 12);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        set_slot(i, 1'($urandom), AW'($urandom_range(0, 15)), $urandom, 4'($urandom));
        req_lock[i] = ($urandom_range(0, 3) == 0);
      end
      req = N'($urandom);
      sleep = ($urandom_range(0, 7) == 0);
      cycle(g, rv, rd);
    end
    req = '0; req_lock = '0; sleep = 1'b0;
    repeat (RL + 1) cycle(g, rv, rd);

    // Reset with two reads in the tag pipe.
    set_slot(0, 1'b0, 10'h3, '0, 4'h0);
    set_slot(1, 1'b0, 10'h4, '0, 4'h0);
    req = 4'b0001;
    cycle(g, rv, rd);
    req = 4'b0010;
    cycle(g, rv, rd);
    req = 4'b1111;
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_rvalid", rvalid, '0);
    repeat (2) begin
      @(negedge aclk);
      chk("midrst_gnt", gnt, '0);
      chk("midrst_cs", mem_cs, 1'b0);
      chk("midrst_rvalid_hold", rvalid, '0);
    end
    @(posedge aclk);
    #1;
    req = '0;
    aresetn = 1'b1;
    repeat (RL + 2) cycle(g, rv, rd);
    req = 4'b1111;
    cycle(g, rv, rd);
    chk("post_rst_first", g, 4'b0001);
    req = '0;
    repeat (RL + 1) cycle(g, rv, rd);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
